// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical pixel counters plus registered
// one-pixel set/clear strobes that drive external JK flip-flops (74112 style).
module video_timing_gen #(
    parameter int H_TOTAL  = 384,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 296,
    parameter int HS_END   = 328,
    parameter int V_TOTAL  = 264,
    parameter int VB_START = 240,
    parameter int VB_END   = 0,
    parameter int VS_START = 248,
    parameter int VS_END   = 252
) (
    input  logic       Clk,
    input  logic       Clear_bar,
    input  logic       Cen,
    output logic [8:0] HCount,
    output logic [8:0] VCount,
    output logic [3:0] J,
    output logic [3:0] K,
    output logic       LineStart,
    output logic       FrameStart
);

    localparam bit H_OK = (H_TOTAL >= 2) && (H_TOTAL <= 512)
                       && (HB_START >= 0) && (HB_START < H_TOTAL)
                       && (HB_END   >= 0) && (HB_END   < H_TOTAL)
                       && (HS_START >= 0) && (HS_START < H_TOTAL)
                       && (HS_END   >= 0) && (HS_END   < H_TOTAL)
                       && (HB_START != HB_END) && (HS_START != HS_END);

    localparam bit V_OK = (V_TOTAL >= 2) && (V_TOTAL <= 512)
                       && (VB_START >= 0) && (VB_START < V_TOTAL)
                       && (VB_END   >= 0) && (VB_END   < V_TOTAL)
                       && (VS_START >= 0) && (VS_START < V_TOTAL)
                       && (VS_END   >= 0) && (VS_END   < V_TOTAL)
                       && (VB_START != VB_END) && (VS_START != VS_END);

    // A START equal to its END would make J and K fire together.
    if (!H_OK) begin : g_bad_h_params
        $error("video_timing_gen: illegal horizontal timing parameters");
    end
    if (!V_OK) begin : g_bad_v_params
        $error("video_timing_gen: illegal vertical timing parameters");
    end

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] HB_SET   = 9'(HB_START);
    localparam logic [8:0] HB_CLR   = 9'(HB_END);
    localparam logic [8:0] HS_SET   = 9'(HS_START);
    localparam logic [8:0] HS_CLR   = 9'(HS_END);
    localparam logic [8:0] VB_SET   = 9'(VB_START);
    localparam logic [8:0] VB_CLR   = 9'(VB_END);
    localparam logic [8:0] VS_SET   = 9'(VS_START);
    localparam logic [8:0] VS_CLR   = 9'(VS_END);

    logic [8:0] next_h;
    logic [8:0] next_v;
    logic       next_line;
    logic [3:0] next_j;
    logic [3:0] next_k;

    // Strobes are decoded from the count the edge is about to load, so the
    // registered outputs always describe the post-edge HCount/VCount.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        next_h    = HCount + 9'd1;
        next_v    = VCount;
        next_line = 1'b0;
        next_j    = 4'b0000;
        next_k    = 4'b0000;

        if (HCount == H_LAST) begin
            next_h = 9'd0;
            next_v = (VCount == V_LAST) ? 9'd0 : VCount + 9'd1;
        end

        next_line = (next_h == 9'd0);

        next_j[0] = (next_h == HB_SET);
        next_k[0] = (next_h == HB_CLR);
        next_j[1] = (next_h == HS_SET);
        next_k[1] = (next_h == HS_CLR);
        next_j[2] = next_line && (next_v == VB_SET);
        next_k[2] = next_line && (next_v == VB_CLR);
        next_j[3] = next_line && (next_v == VS_SET);
        next_k[3] = next_line && (next_v == VS_CLR);
    end

    // Reset clears the strobes even though count 0 would normally decode some.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            HCount     <= 9'd0;
            VCount     <= 9'd0;
            J          <= 4'b0000;
            K          <= 4'b0000;
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
        end else if (Cen) begin
            // NOTE: non-blocking assignments make every register load from pre-edge values.
            HCount     <= next_h;
            VCount     <= next_v;
            J          <= next_j;
            K          <= next_k;
            LineStart  <= next_line;
            FrameStart <= next_line && (next_v == 9'd0);
        end
    end

    jk_exclusive: assert property (@(posedge Clk) disable iff (!Clear_bar) (J & K) == 4'b0000)
        else $error("video_timing_gen: J and K asserted together");

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a default-timing instance and a shrunken-timing instance
// run side by side against an arithmetic raster model and a 74112 scoreboard.
module tb_video_timing_gen;

    localparam int S_HT  = 40;
    localparam int S_HBS = 26;
    localparam int S_HBE = 0;
    localparam int S_HSS = 30;
    localparam int S_HSE = 34;
    localparam int S_VT  = 30;
    localparam int S_VBS = 24;
    localparam int S_VBE = 0;
    localparam int S_VSS = 26;
    localparam int S_VSE = 28;

    typedef struct {
        int ht, hbs, hbe, hss, hse, vt, vbs, vbe, vss, vse;
    } tim_t;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic [3:0] j;
        logic [3:0] k;
        logic       ls;
        logic       fs;
    } obs_t;

    logic       Clk;
    logic       Clear_bar;
    logic       Cen;
    logic [8:0] d_h, d_v, s_h, s_v;
    logic [3:0] d_j, d_k, s_j, s_k;
    logic       d_ls, d_fs, s_ls, s_fs;

    int   n_compared;
    int   n_mismatched;
    int   n;              // enabled edges since the last reset release
    tim_t p_def;
    tim_t p_sml;
    logic sb_q[4];
    int   sb_run[4];
    int   sb_width[4];

    video_timing_gen dut (
        .Clk(Clk), .Clear_bar(Clear_bar), .Cen(Cen),
        .HCount(d_h), .VCount(d_v), .J(d_j), .K(d_k),
        .LineStart(d_ls), .FrameStart(d_fs)
    );

    video_timing_gen #(
        .H_TOTAL(S_HT), .HB_START(S_HBS), .HB_END(S_HBE),
        .HS_START(S_HSS), .HS_END(S_HSE),
        .V_TOTAL(S_VT), .VB_START(S_VBS), .VB_END(S_VBE),
        .VS_START(S_VSS), .VS_END(S_VSE)
    ) dut_s (
        .Clk(Clk), .Clear_bar(Clear_bar), .Cen(Cen),
        .HCount(s_h), .VCount(s_v), .J(s_j), .K(s_k),
        .LineStart(s_ls), .FrameStart(s_fs)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Position in the raster is just the enabled-edge count folded by the totals.
    function automatic obs_t model(input tim_t p, input int edges);
        obs_t o;
        int   h, v;
        o = '0;
        if (edges == 0) return o;
        h = edges % p.ht;
        v = (edges / p.ht) % p.vt;
        o.h    = 9'(h);
        o.v    = 9'(v);
        o.j[0] = (h == p.hbs);
        o.k[0] = (h == p.hbe);
        o.j[1] = (h == p.hss);
        o.k[1] = (h == p.hse);
        o.j[2] = (h == 0) && (v == p.vbs);
        o.k[2] = (h == 0) && (v == p.vbe);
        o.j[3] = (h == 0) && (v == p.vss);
        o.k[3] = (h == 0) && (v == p.vse);
        o.ls   = (h == 0);
        o.fs   = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t obs_def();
        return '{h: d_h, v: d_v, j: d_j, k: d_k, ls: d_ls, fs: d_fs};
    endfunction

    function automatic obs_t obs_sml();
        return '{h: s_h, v: s_v, j: s_j, k: s_k, ls: s_ls, fs: s_fs};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d j=%b k=%b ls=%b fs=%b", o.h, o.v, o.j, o.k, o.ls, o.fs);
    endfunction

    task automatic sb_clear();
        for (int i = 0; i < 4; i++) begin
            sb_q[i]   = 1'b0;
            sb_run[i] = 0;
        end
    endtask

    // One Clk cycle; J/K seen now are what the downstream 74112s sample next edge.
    task automatic tick(input logic c);
        logic [3:0] jv, kv;
        Cen = c;
        if (Clear_bar) begin
            n_compared++;
            if (((d_j & d_k) | (s_j & s_k)) !== 4'b0000) begin
                n_mismatched++;
                $display("FAIL jk_exclusive n=%0d def j=%b k=%b small j=%b k=%b", n, d_j, d_k, s_j, s_k);
            end
            if (c) begin
                jv = {s_j[1], s_j[0], d_j[1], d_j[0]};
                kv = {s_k[1], s_k[0], d_k[1], d_k[0]};
                for (int i = 0; i < 4; i++) begin
                    if (jv[i]) begin
                        sb_q[i]   = 1'b1;
                        sb_run[i] = 1;
                    end else if (kv[i]) begin
                        if (sb_q[i]) begin
                            n_compared++;
                            if (sb_run[i] != sb_width[i]) begin
                                n_mismatched++;
                                $display("FAIL jk_pulse_width ch=%0d got %0d pixels, want %0d", i, sb_run[i], sb_width[i]);
                            end
                        end
                        sb_q[i]   = 1'b0;
                        sb_run[i] = 0;
                    end else if (sb_q[i]) begin
                        sb_run[i]++;
                    end
                end
            end
        end
        @(posedge Clk);
        #1;
        if (c && Clear_bar) n++;
    endtask

    task automatic do_reset();
        Clear_bar = 1'b0;
        n = 0;
        sb_clear();
        tick(1'b1);
        tick(1'b0);
        Clear_bar = 1'b1;
    endtask

    task automatic test_reset();
        obs_t a_d, a_s;
        Clear_bar = 1'b0;
        Cen = 1'b0;
        n = 0;
        sb_clear();
        #2;
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if ({obs_def(), obs_sml()} !== '0) begin
                n_mismatched++;
                $display("FAIL reset_hold i=%0d def %s small %s", i, fmt(obs_def()), fmt(obs_sml()));
            end
            tick(1'($urandom_range(0, 1)));
        end
        Clear_bar = 1'b1;
        tick(1'b1);
        a_d = obs_def();
        a_s = obs_sml();
        n_compared++;
        if (a_d.h !== 9'd1 || a_d.v !== 9'd0 || a_s.h !== 9'd1 || a_s.v !== 9'd0 || a_d.j !== 4'b0 || a_d.k !== 4'b0) begin
            n_mismatched++;
            $display("FAIL first_edge def %s small %s, want h=1 v=0 no strobes", fmt(a_d), fmt(a_s));
        end
        tick(1'b0);
        n_compared++;
        if (d_h !== 9'd1 || s_h !== 9'd1) begin
            n_mismatched++;
            $display("FAIL cen_low_hold def h=%0d small h=%0d, want 1", d_h, s_h);
        end
    endtask

    task automatic test_free_run();
        int pulses[$];
        do_reset();
        for (int i = 0; i < 3 * 384 + 10; i++) begin
            tick(1'b1);
            n_compared++;
            if ({obs_def(), obs_sml()} !== {model(p_def, n), model(p_sml, n)}) begin
                n_mismatched++;
                $display("FAIL free_run n=%0d def %s / %s small %s / %s", n,
                         fmt(obs_def()), fmt(model(p_def, n)), fmt(obs_sml()), fmt(model(p_sml, n)));
            end
            if (d_j[0]) pulses.push_back(n);
        end
        n_compared++;
        if (pulses.size() != 3) begin
            n_mismatched++;
            $display("FAIL hblank_set_count got %0d pulses, want 3", pulses.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_compared++;
                if (pulses[i] != 256 + 384 * i) begin
                    n_mismatched++;
                    $display("FAIL hblank_set_pos pulse %0d at edge %0d, want %0d", i, pulses[i], 256 + 384 * i);
                end
            end
        end
    endtask

    task automatic test_cen_quarter();
        int phase, width, seen;
        do_reset();
        phase = $urandom_range(0, 3);
        width = 0;
        seen  = 0;
        for (int i = 0; i < 4 * 420; i++) begin
            tick(1'((i % 4) == phase));
            n_compared++;
            if ({obs_def(), obs_sml()} !== {model(p_def, n), model(p_sml, n)}) begin
                n_mismatched++;
                $display("FAIL cen_quarter i=%0d def %s / %s small %s / %s", i,
                         fmt(obs_def()), fmt(model(p_def, n)), fmt(obs_sml()), fmt(model(p_sml, n)));
            end
            if (d_j[1]) begin
                width++;
            end else if (width != 0) begin
                seen++;
                n_compared++;
                if (width != 4) begin
                    n_mismatched++;
                    $display("FAIL cen_quarter_width hsync set held %0d clocks, want 4", width);
                end
                width = 0;
            end
        end
        n_compared++;
        if (seen != 1) begin
            n_mismatched++;
            $display("FAIL cen_quarter_pulses got %0d hsync set pulses, want 1", seen);
        end
    endtask

    task automatic test_reset_mid_line();
        int first_hs;
        do_reset();
        while (n < 300) tick(1'b1);
        n_compared++;
        if (d_h !== 9'd300) begin
            n_mismatched++;
            $display("FAIL mid_line_position got h=%0d, want 300", d_h);
        end
        #2;
        Clear_bar = 1'b0;
        n = 0;
        sb_clear();
        #1;
        n_compared++;
        if ({obs_def(), obs_sml()} !== '0) begin
            n_mismatched++;
            $display("FAIL async_reset def %s small %s, want all zero", fmt(obs_def()), fmt(obs_sml()));
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            n_compared++;
            if ({obs_def(), obs_sml()} !== '0) begin
                n_mismatched++;
                $display("FAIL reset_clocked i=%0d def %s small %s", i, fmt(obs_def()), fmt(obs_sml()));
            end
        end
        Clear_bar = 1'b1;
        first_hs = -1;
        while (n < 400) begin
            tick(1'b1);
            n_compared++;
            if ({obs_def(), obs_sml()} !== {model(p_def, n), model(p_sml, n)}) begin
                n_mismatched++;
                $display("FAIL after_reset n=%0d def %s / %s small %s / %s", n,
                         fmt(obs_def()), fmt(model(p_def, n)), fmt(obs_sml()), fmt(model(p_sml, n)));
            end
            if (d_j[1] && first_hs < 0) first_hs = n;
        end
        n_compared++;
        if (first_hs != 296) begin
            n_mismatched++;
            $display("FAIL hsync_after_reset first set at edge %0d, want 296", first_hs);
        end
    endtask

    task automatic test_frame_wrap();
        int fs_at[$];
        int cnt_j2, cnt_k2, cnt_j3, cnt_k3;
        do_reset();
        cnt_j2 = 0; cnt_k2 = 0; cnt_j3 = 0; cnt_k3 = 0;
        for (int i = 0; i < 2 * S_HT * S_VT + 5; i++) begin
            tick(1'b1);
            n_compared++;
            if ({obs_def(), obs_sml()} !== {model(p_def, n), model(p_sml, n)}) begin
                n_mismatched++;
                $display("FAIL frame_wrap n=%0d def %s / %s small %s / %s", n,
                         fmt(obs_def()), fmt(model(p_def, n)), fmt(obs_sml()), fmt(model(p_sml, n)));
            end
            if (s_fs) fs_at.push_back(n);
            cnt_j2 += int'(s_j[2]);
            cnt_k2 += int'(s_k[2]);
            cnt_j3 += int'(s_j[3]);
            cnt_k3 += int'(s_k[3]);
        end
        n_compared++;
        if (fs_at.size() != 2 || fs_at[0] != S_HT * S_VT || fs_at[1] != 2 * S_HT * S_VT) begin
            n_mismatched++;
            $display("FAIL frame_start got %0d pulses (first at %0d), want 2 at %0d and %0d",
                     fs_at.size(), (fs_at.size() > 0) ? fs_at[0] : -1, S_HT * S_VT, 2 * S_HT * S_VT);
        end
        n_compared++;
        if (cnt_j2 != 2 || cnt_k2 != 2 || cnt_j3 != 2 || cnt_k3 != 2) begin
            n_mismatched++;
            $display("FAIL vertical_strobes j2=%0d k2=%0d j3=%0d k3=%0d, want 2 each", cnt_j2, cnt_k2, cnt_j3, cnt_k3);
        end
    endtask

    task automatic test_random();
        int rst_at;
        logic c;
        do_reset();
        rst_at = $urandom_range(500, 3500);
        for (int i = 0; i < 4000; i++) begin
            if (i == rst_at) begin
                Clear_bar = 1'b0;
                n = 0;
                sb_clear();
            end
            if (i == rst_at + 2) Clear_bar = 1'b1;
            c = 1'($urandom_range(0, 2) != 0);
            tick(c);
            n_compared++;
            if ({obs_def(), obs_sml()} !== {model(p_def, n), model(p_sml, n)}) begin
                n_mismatched++;
                $display("FAIL random i=%0d n=%0d def %s / %s small %s / %s", i, n,
                         fmt(obs_def()), fmt(model(p_def, n)), fmt(obs_sml()), fmt(model(p_sml, n)));
            end
        end
    endtask

    initial begin
        Clear_bar    = 1'b0;
        Cen          = 1'b0;
        n_compared   = 0;
        n_mismatched = 0;
        n            = 0;
        p_def = '{384, 256, 0, 296, 328, 264, 240, 0, 248, 252};
        p_sml = '{S_HT, S_HBS, S_HBE, S_HSS, S_HSE, S_VT, S_VBS, S_VBE, S_VSS, S_VSE};
        sb_width[0] = 128;
        sb_width[1] = 32;
        sb_width[2] = S_HT - S_HBS + S_HBE;
        sb_width[3] = S_HSE - S_HSS;

        test_reset();
        test_free_run();
        test_cen_quarter();
        test_reset_mid_line();
        test_frame_wrap();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_TOTAL, default 384: pixels per line; HCount runs 0..H_TOTAL-1.
REQ-002 Parameter HB_START, default 256: HCount value at which the HBLANK set strobe fires.
REQ-003 Parameter HB_END, default 0: HCount value at which the HBLANK clear strobe fires.
REQ-004 Parameter HS_START, default 296 and HS_END, default 328: HSYNC set and clear HCount values.
REQ-005 Parameter V_TOTAL, default 264: lines per frame; VCount runs 0..V_TOTAL-1.
REQ-006 Parameter VB_START, default 240 and VB_END, default 0: VBLANK set and clear VCount values.
REQ-007 Parameter VS_START, default 248 and VS_END, default 252: VSYNC set and clear VCount values.
REQ-008 Clk  input  1  system clock; all state changes on the rising edge.
REQ-009 Clear_bar  input  1  reset; asynchronous, active-low.
REQ-010 Cen  input  1  pixel clock enable; the block advances only on Clk edges where Cen=1.
REQ-011 HCount  output  9  current horizontal pixel count.
REQ-012 VCount  output  9  current line count.
REQ-013 J  output  4  set strobes for the downstream JK stages: bit0 HBLANK, bit1 HSYNC, bit2 VBLANK, bit3 VSYNC.
REQ-014 K  output  4  clear strobes for the same four JK stages, using the same bit order.
REQ-015 LineStart  output  1  high while HCount=0.
REQ-016 FrameStart  output  1  high while HCount=0 and VCount=0.

Function
REQ-017 All outputs SHALL be registered; every output SHALL be a function of the post-edge HCount/VCount value.
REQ-018 On a Clk edge with Cen=1, HCount SHALL increment by 1 and wrap from H_TOTAL-1 to 0.
REQ-019 VCount SHALL increment only on the edge where HCount wraps to 0, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-020 On edges with Cen=0, all registers including J, K, LineStart and FrameStart SHALL hold their values.
REQ-021 J[0] SHALL be 1 exactly while HCount=HB_START; K[0] SHALL be 1 exactly while HCount=HB_END.
REQ-022 J[1] SHALL be 1 exactly while HCount=HS_START; K[1] SHALL be 1 exactly while HCount=HS_END.
REQ-023 J[2] SHALL be 1 exactly while HCount=0 and VCount=VB_START; K[2] SHALL be 1 exactly while HCount=0 and VCount=VB_END.
REQ-024 J[3] SHALL be 1 exactly while HCount=0 and VCount=VS_START; K[3] SHALL be 1 exactly while HCount=0 and VCount=VS_END.
REQ-025 Strobe width SHALL be one Cen period; J[i] and K[i] SHALL never both be 1, which requires START≠END for every pair.
REQ-026 Parameter legality is required: every START/END value < its TOTAL, and H_TOTAL, V_TOTAL ≤ 512.
REQ-027 Illegal parameters SHALL raise a simulation-time error; synthesis behaviour for illegal parameters is undefined.
REQ-028 Simultaneous H and V events on the same edge SHALL each assert their own bit independently.

Reset
REQ-029 Clear_bar=0 SHALL immediately force HCount=0, VCount=0, J=0, K=0, LineStart=0 and FrameStart=0, regardless of Clk and Cen.
REQ-030 After release, the first Cen=1 edge SHALL produce HCount=1, VCount=0; strobes SHALL resume at the next decoded count.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no partial strobe held, and no J/K bit SHALL be high during reset.
REQ-032 Reset release SHALL be synchronised externally; the block does not resynchronise Clear_bar.

Verification
REQ-033 Free-run, defaults, Cen=1 every cycle -> J[0] pulses every 384 Clk edges at HCount=256; K[0] pulses at HCount=0.
REQ-034 Frame wrap: run 384*264 enabled edges from reset -> HCount=0, VCount=0 and FrameStart=1 exactly once per 101376 enabled edges.
REQ-035 Cen=1 one cycle in four -> HCount advances once per 4 Clk edges, and each strobe width equals 4 Clk periods.
REQ-036 Vertical strobes: at VCount=240 with HCount=0 -> J[2]=1 for one Cen period; at VCount=248 -> J[3]=1; at VCount=252 -> K[3]=1.
REQ-037 Reset mid-line at HCount=300, during J[1] hold-off -> all outputs 0 immediately; after release, J[1] next fires at HCount=296 of line 0.
REQ-038 Scoreboard checks, all cycles:
- J&K == 0 at all times.
- Downstream 74112 model fed by J/K shows HBLANK high for 128 pixels and HSYNC high for 32 pixels per line.
